breathe_sequencer: RTL

BREATHE_SEQUENCER -- requirements
Module: breathe_sequencer

---
 rtl/breathe_sequencer_pkg.sv | 26 ++
 rtl/breathe_pwm_chan.sv | 40 ++++
 rtl/breathe_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/breathe_sequencer_pkg.sv
// Shared types and defaults for the LED breathe sequencer: FSM states,
// command mode encodings and default parameter values.
package breathe_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HI   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LO   = 3'd4,
    ST_SOLID     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_CONT   = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_DIV_BITS = 16;
  localparam int HOLD_BITS    = 8;

endpackage

// File: rtl/breathe_pwm_chan.sv
// One LED channel: compares the shared PWM counter against the shared duty,
// gates with the channel mask and registers the result.
module breathe_pwm_chan
  import breathe_sequencer_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mask_bit,
  input  logic                pwm_en,
  input  logic                solid_en,
  input  logic [PWM_BITS-1:0] pwm_ctr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  logic led_d;
  logic led_q;

  always_comb begin
    led_d = 1'b0;
    if (solid_en) begin
      led_d = mask_bit;
    end else if (pwm_en) begin
      led_d = mask_bit & (pwm_ctr < duty);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/breathe_sequencer.sv
// Multi-channel LED breathe sequencer: ramps a brightness level up and down
// and drives masked PWM outputs. Define BREATHE_SEQ_GAMMA_EN for squared duty.
module breathe_sequencer
  import breathe_sequencer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int DIV_BITS = DEF_DIV_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [NUM_CH-1:0]    cmd_ch_mask,
  input  logic [DIV_BITS-1:0]  cmd_step_div,
  input  logic [HOLD_BITS-1:0] cmd_hold_steps,
  output logic [NUM_CH-1:0]    led,
  output logic                 busy,
  output logic                 done
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic [DIV_BITS-1:0]    div_q, div_d;
  logic [DIV_BITS-1:0]    presc_q, presc_d;
  logic [HOLD_BITS-1:0]   hold_q, hold_d;
  logic [HOLD_BITS-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PWM_BITS-1:0]    level_q, level_d;
  logic [PWM_BITS-1:0]    pwm_q, pwm_d;
  logic                   done_q, done_d;

  logic                   breathing;
  logic                   tick;
  logic                   accept;
  logic [HOLD_BITS:0]     hold_next;
  logic                   hold_exit;
  logic [PWM_BITS-1:0]    duty;

  // Handshake: a command transfers on every rising edge where cmd_valid and
  // cmd_ready are both high; cmd_valid may stay high while cmd_ready is low.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    div_d      = div_q;
    presc_d    = presc_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    pwm_d      = pwm_q + PWM_BITS'(1);
    done_d     = 1'b0;

    breathing = (state_q == ST_RAMP_UP) || (state_q == ST_HOLD_HI) ||
                (state_q == ST_RAMP_DOWN) || (state_q == ST_HOLD_LO);
    tick      = breathing && (presc_q == div_q);
    hold_next = {1'b0, hold_cnt_q} + (HOLD_BITS + 1)'(1);
    hold_exit = hold_next >= {1'b0, hold_q};
    cmd_ready = (state_q == ST_IDLE) || (state_q == ST_SOLID) || (mode_q == MODE_CONT);
    accept    = cmd_valid && cmd_ready;

    if (breathing) begin
      presc_d = tick ? '0 : presc_q + DIV_BITS'(1);
    end

    // A new command restarts the sequence and swallows any coincident tick.
    if (accept) begin
      mode_d     = mode_e'(cmd_mode);
      mask_d     = cmd_ch_mask;
      div_d      = cmd_step_div;
      hold_d     = cmd_hold_steps;
      presc_d    = '0;
      level_d    = '0;
      hold_cnt_d = '0;
      case (mode_e'(cmd_mode))
        MODE_SINGLE, MODE_CONT: state_d = ST_RAMP_UP;
        MODE_SOLID:             state_d = ST_SOLID;
        default:                state_d = ST_IDLE;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_RAMP_UP: begin
          if (level_q == LEVEL_MAX) state_d = ST_HOLD_HI;
          else                      level_d = level_q + PWM_BITS'(1);
        end
        ST_HOLD_HI: begin
          if (hold_exit) begin
            hold_cnt_d = '0;
            state_d    = ST_RAMP_DOWN;
          end else begin
            hold_cnt_d = hold_next[HOLD_BITS-1:0];
          end
        end
        ST_RAMP_DOWN: begin
          if (level_q == '0) state_d = ST_HOLD_LO;
          else               level_d = level_q - PWM_BITS'(1);
        end
        ST_HOLD_LO: begin
          if (hold_exit) begin
            hold_cnt_d = '0;
            if (mode_q == MODE_CONT) begin
              state_d = ST_RAMP_UP;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_next[HOLD_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_OFF;
      mask_q     <= '0;
      div_q      <= '0;
      presc_q    <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      level_q    <= '0;
      pwm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      pwm_q      <= pwm_d;
      done_q     <= done_d;
    end
  end

`ifdef BREATHE_SEQ_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
  assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level_q;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    breathe_pwm_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .mask_bit (mask_q[i]),
      .pwm_en   (breathing),
      .solid_en (state_q == ST_SOLID),
      .pwm_ctr  (pwm_q),
      .duty     (duty),
      .led      (led[i])
    );
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
